// File: rtl/microcode_sequencer.sv
// Microprogrammed control sequencer: steps a micro-PC through a loadable microcode
// store and drives the selected control word to the multicycle datapath.
module microcode_sequencer #(
    parameter int CW_WIDTH     = 24,
    parameter int UADDR_WIDTH  = 5,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [OPCODE_WIDTH-1:0]           opcode_i,
    input  logic                              eqb_i,
    input  logic                              mem_ready_i,
    input  logic                              load_en_i,
    input  logic                              load_sel_i,
    input  logic [UADDR_WIDTH-1:0]            load_addr_i,
    input  logic [CW_WIDTH+UADDR_WIDTH+4-1:0] load_data_i,
    output logic [CW_WIDTH-1:0]               ctrl_o,
    output logic [UADDR_WIDTH-1:0]            upc_o,
    output logic                              running_o,
    output logic                              halted_o,
    output logic                              seq_err_o,
    output logic [15:0]                       cycle_count_o
);

    localparam int UW_WIDTH = CW_WIDTH + UADDR_WIDTH + 4;
    localparam int DEPTH    = 1 << UADDR_WIDTH;
    localparam int TDEPTH   = 1 << OPCODE_WIDTH;

    localparam logic [2:0] SEQ_NEXT     = 3'b000;
    localparam logic [2:0] SEQ_FETCH    = 3'b001;
    localparam logic [2:0] SEQ_DISPATCH = 3'b010;
    localparam logic [2:0] SEQ_BRANCH   = 3'b011;
    localparam logic [2:0] SEQ_HALT     = 3'b100;

    localparam logic [UADDR_WIDTH-1:0] UPC_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t                   state_q, state_d;
    logic [UADDR_WIDTH-1:0]   upc_q, upc_d;
    logic                     seq_err_q, seq_err_d;
    logic [15:0]              cnt_q, cnt_d;

    logic [UW_WIDTH-1:0]      store_q [DEPTH];
    logic [UADDR_WIDTH-1:0]   table_q [TDEPTH];

    logic [UW_WIDTH-1:0]      uword;
    logic [CW_WIDTH-1:0]      w_ctrl;
    logic [UADDR_WIDTH-1:0]   w_target;
    logic [2:0]               w_seq;
    logic                     w_wait;
    logic [UADDR_WIDTH-1:0]   upc_inc;

    assign uword    = store_q[upc_q];
    assign w_ctrl   = uword[CW_WIDTH-1:0];
    assign w_target = uword[CW_WIDTH +: UADDR_WIDTH];
    assign w_seq    = uword[CW_WIDTH+UADDR_WIDTH +: 3];
    assign w_wait   = uword[UW_WIDTH-1];
    assign upc_inc  = upc_q + UPC_ONE;

    // Contents survive reset; writes are locked out while the program runs.
    always_ff @(posedge clk) begin
        if (load_en_i && (state_q != ST_RUN)) begin
            if (load_sel_i) begin
                table_q[load_addr_i[OPCODE_WIDTH-1:0]] <= load_data_i[UADDR_WIDTH-1:0];
            end else begin
                store_q[load_addr_i] <= load_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            upc_q     <= '0;
            seq_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            seq_err_q <= seq_err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        seq_err_d = seq_err_q;
        cnt_d     = cnt_q;
        ctrl_o    = '0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    upc_d     = '0;
                    cnt_d     = '0;
                    seq_err_d = 1'b0;
                end
            end
            ST_RUN: begin
                ctrl_o = w_ctrl;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                // A waiting word with memory not ready holds everything but the counter.
                if (!(w_wait && !mem_ready_i)) begin
                    case (w_seq)
                        SEQ_NEXT:     upc_d = upc_inc;
                        SEQ_FETCH:    upc_d = '0;
                        SEQ_DISPATCH: upc_d = table_q[opcode_i];
                        SEQ_BRANCH:   upc_d = eqb_i ? w_target : upc_inc;
                        SEQ_HALT:     state_d = ST_HALT;
                        default: begin
                            state_d   = ST_HALT;
                            seq_err_d = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign upc_o         = upc_q;
    assign running_o     = (state_q == ST_RUN);
    assign halted_o      = (state_q == ST_HALT);
    assign seq_err_o     = seq_err_q;
    assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus randomized programs
// compared cycle by cycle with a behavioural model of the sequencer.
module tb_microcode_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic        eqb;
    logic        mem_ready;
    logic        load_en;
    logic        load_sel;
    logic [4:0]  load_addr;
    logic [32:0] load_data;
    logic [23:0] ctrl;
    logic [4:0]  upc;
    logic        running;
    logic        halted;
    logic        seq_err;
    logic [15:0] cycle_count;

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model
    logic [32:0] mstore [32];
    logic [4:0]  mtable [16];
    bit          m_run, m_halt, m_err;
    int          m_upc, m_cnt;

    microcode_sequencer #(.CW_WIDTH(24), .UADDR_WIDTH(5), .OPCODE_WIDTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .opcode_i      (opcode),
        .eqb_i         (eqb),
        .mem_ready_i   (mem_ready),
        .load_en_i     (load_en),
        .load_sel_i    (load_sel),
        .load_addr_i   (load_addr),
        .load_data_i   (load_data),
        .ctrl_o        (ctrl),
        .upc_o         (upc),
        .running_o     (running),
        .halted_o      (halted),
        .seq_err_o     (seq_err),
        .cycle_count_o (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] mk(bit wt, logic [2:0] sq, logic [4:0] tg, logic [23:0] cw);
        return {wt, sq, tg, cw};
    endfunction

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_err = 0; m_upc = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [32:0] w;
        if (!m_run) begin
            if (load_en) begin
                if (load_sel) mtable[load_addr[3:0]] = load_data[4:0];
                else mstore[load_addr] = load_data;
            end
            if (start) begin
                m_run = 1; m_halt = 0; m_upc = 0; m_cnt = 0; m_err = 0;
            end
        end else begin
            w = mstore[m_upc];
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (!(w[32] && !mem_ready)) begin
                case (int'(w[31:29]))
                    0: m_upc = (m_upc + 1) % 32;
                    1: m_upc = 0;
                    2: m_upc = int'(mtable[opcode]);
                    3: m_upc = eqb ? int'(w[28:24]) : (m_upc + 1) % 32;
                    4: begin m_run = 0; m_halt = 1; end
                    default: begin m_run = 0; m_halt = 1; m_err = 1; end
                endcase
            end
        end
    endtask

    function automatic logic [23:0] model_ctrl();
        logic [32:0] w;
        w = mstore[m_upc];
        return m_run ? w[23:0] : 24'h0;
    endfunction

    // one clock: inputs are stable here, DUT and model both take the edge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load(bit sel, logic [4:0] addr, logic [32:0] data);
        load_en = 1; load_sel = sel; load_addr = addr; load_data = data;
        cycle();
        load_en = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        cycle();
        start = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic fill_halt();
        for (int a = 0; a < 32; a++) load(1'b0, 5'(a), mk(0, 3'b100, 5'd0, 24'h0));
        for (int a = 0; a < 16; a++) load(1'b1, 5'(a), 33'd0);
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (ctrl !== 24'h0) $display("FAIL reset ctrl: got %h want 0", ctrl); else n_pass++;
        n_total++; if (upc !== 5'd0) $display("FAIL reset upc: got %0d want 0", upc); else n_pass++;
        n_total++; if ({running, halted, seq_err} !== 3'b000) $display("FAIL reset flags: got %b want 000", {running, halted, seq_err}); else n_pass++;
        n_total++; if (cycle_count !== 16'd0) $display("FAIL reset count: got %0d want 0", cycle_count); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        #1;
        cycle();
        n_total++; if ({running, halted, upc, ctrl} !== 32'h0) $display("FAIL idle outputs: got %b/%b/%0d/%h want all zero", running, halted, upc, ctrl); else n_pass++;
    endtask

    task automatic test_linear();
        load(0, 5'd0, mk(0, 3'b000, 5'd0, 24'h000001));
        load(0, 5'd1, mk(0, 3'b000, 5'd0, 24'h000002));
        load(0, 5'd2, mk(0, 3'b000, 5'd0, 24'h000004));
        load(0, 5'd3, mk(0, 3'b100, 5'd0, 24'h000008));
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            n_total++; if (ctrl !== (24'h1 << i)) $display("FAIL linear ctrl[%0d]: got %h want %h", i, ctrl, 24'h1 << i); else n_pass++;
            n_total++; if (upc !== 5'(i) || running !== 1'b1) $display("FAIL linear upc[%0d]: got %0d run %b want %0d run 1", i, upc, running, i); else n_pass++;
            cycle();
        end
        n_total++; if (halted !== 1'b1 || running !== 1'b0) $display("FAIL linear halted: got %b want 1", halted); else n_pass++;
        n_total++; if (ctrl !== 24'h0) $display("FAIL linear halt ctrl: got %h want 0", ctrl); else n_pass++;
        n_total++; if (cycle_count !== 16'd4) $display("FAIL linear count: got %0d want 4", cycle_count); else n_pass++;
        n_total++; if (upc !== 5'd3) $display("FAIL linear frozen upc: got %0d want 3", upc); else n_pass++;
    endtask

    task automatic test_dispatch();
        logic [3:0] opc [2];
        int         dst [2];
        opc[0] = 4'h3; dst[0] = 10;
        opc[1] = 4'hC; dst[1] = 20;
        load(1, 5'h03, 33'd10);
        load(1, 5'h0C, 33'd20);
        load(0, 5'd0, mk(0, 3'b000, 5'd0, 24'h000010));
        load(0, 5'd1, mk(0, 3'b010, 5'd0, 24'h000020));
        load(0, 5'd10, mk(0, 3'b100, 5'd0, 24'h00000A));
        load(0, 5'd20, mk(0, 3'b100, 5'd0, 24'h000014));
        for (int r = 0; r < 2; r++) begin
            opcode = opc[r];
            pulse_start();
            n_total++; if (upc !== 5'd0) $display("FAIL dispatch%0d upc0: got %0d want 0", r, upc); else n_pass++;
            cycle();
            n_total++; if (upc !== 5'd1 || ctrl !== 24'h20) $display("FAIL dispatch%0d word1: got %0d/%h want 1/20", r, upc, ctrl); else n_pass++;
            cycle();
            n_total++; if (upc !== 5'(dst[r])) $display("FAIL dispatch%0d target: got %0d want %0d", r, upc, dst[r]); else n_pass++;
            n_total++; if (ctrl !== 24'(dst[r])) $display("FAIL dispatch%0d target ctrl: got %h want %h", r, ctrl, 24'(dst[r])); else n_pass++;
            cycle();
            n_total++; if (halted !== 1'b1) $display("FAIL dispatch%0d halt: got %b want 1", r, halted); else n_pass++;
        end
    endtask

    task automatic test_branch();
        load(0, 5'd1, mk(0, 3'b000, 5'd0, 24'h000021));
        load(0, 5'd2, mk(0, 3'b011, 5'd7, 24'h000022));
        load(0, 5'd3, mk(0, 3'b100, 5'd0, 24'h000023));
        load(0, 5'd7, mk(0, 3'b100, 5'd0, 24'h000027));
        for (int r = 0; r < 2; r++) begin
            eqb = (r == 0);
            pulse_start();
            cycle();
            cycle();
            n_total++; if (upc !== 5'd2) $display("FAIL branch%0d at word2: got %0d want 2", r, upc); else n_pass++;
            cycle();
            n_total++; if (upc !== (r == 0 ? 5'd7 : 5'd3)) $display("FAIL branch%0d dest: got %0d want %0d", r, upc, r == 0 ? 7 : 3); else n_pass++;
            cycle();
        end
        eqb = 0;
    endtask

    task automatic test_stall();
        load(0, 5'd1, mk(1, 3'b000, 5'd0, 24'h000055));
        load(0, 5'd2, mk(0, 3'b100, 5'd0, 24'h000066));
        mem_ready = 0;
        pulse_start();
        for (int k = 1; k <= 4; k++) begin
            cycle();
            n_total++; if (upc !== 5'd1 || ctrl !== 24'h55) $display("FAIL stall hold%0d: got %0d/%h want 1/55", k, upc, ctrl); else n_pass++;
            n_total++; if (cycle_count !== 16'(k)) $display("FAIL stall count%0d: got %0d want %0d", k, cycle_count, k); else n_pass++;
        end
        mem_ready = 1;
        cycle();
        n_total++; if (upc !== 5'd2 || cycle_count !== 16'd5) $display("FAIL stall release: got %0d/%0d want 2/5", upc, cycle_count); else n_pass++;
        cycle();
    endtask

    task automatic test_errors_wrap();
        load(0, 5'd0, mk(0, 3'b110, 5'd0, 24'h000BAD));
        pulse_start();
        n_total++; if (ctrl !== 24'hBAD || seq_err !== 1'b0) $display("FAIL err word: got %h/%b want bad/0", ctrl, seq_err); else n_pass++;
        cycle();
        n_total++; if (halted !== 1'b1 || seq_err !== 1'b1) $display("FAIL err halt: got halted %b err %b want 1/1", halted, seq_err); else n_pass++;
        load(0, 5'd31, mk(0, 3'b000, 5'd0, 24'h000031));
        load(0, 5'd1, mk(0, 3'b100, 5'd0, 24'h000001));
        // new word 0 loaded in the same cycle as start
        eqb = 1;
        load_en = 1; load_sel = 0; load_addr = 5'd0; load_data = mk(0, 3'b011, 5'd31, 24'h000007);
        start = 1;
        cycle();
        load_en = 0; start = 0;
        n_total++; if (seq_err !== 1'b0) $display("FAIL err cleared: got %b want 0", seq_err); else n_pass++;
        n_total++; if (ctrl !== 24'h7) $display("FAIL load+start ctrl: got %h want 7", ctrl); else n_pass++;
        cycle();
        eqb = 0;
        n_total++; if (upc !== 5'd31) $display("FAIL wrap entry: got %0d want 31", upc); else n_pass++;
        cycle();
        n_total++; if (upc !== 5'd0 || running !== 1'b1) $display("FAIL wrap: got %0d run %b want 0 run 1", upc, running); else n_pass++;
        cycle();
        cycle();
        // reset in the middle of RUN must clear outputs without a clock edge
        pulse_start();
        cycle();
        #3;
        rst_n = 0;
        model_reset();
        #1;
        n_total++; if (ctrl !== 24'h0 || running !== 1'b0 || upc !== 5'd0) $display("FAIL midrun reset: got %h/%b/%0d want 0/0/0", ctrl, running, upc); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_load_in_run();
        load(0, 5'd0, mk(0, 3'b000, 5'd0, 24'h0000A0));
        load(0, 5'd1, mk(0, 3'b100, 5'd0, 24'h0000A1));
        pulse_start();
        load_en = 1; load_sel = 0; load_addr = 5'd0; load_data = mk(0, 3'b100, 5'd0, 24'hFFFFFF);
        cycle();
        load_en = 0;
        cycle();
        pulse_start();
        n_total++; if (ctrl !== 24'hA0) $display("FAIL load in run: got %h want a0", ctrl); else n_pass++;
        cycle();
        cycle();
    endtask

    task automatic test_random();
        int r;
        logic [2:0] sq;
        for (int p = 0; p < 6; p++) begin
            apply_reset();
            for (int a = 0; a < 32; a++) begin
                r = $urandom_range(0, 15);
                sq = (r < 5) ? 3'd0 : (r < 7) ? 3'd1 : (r < 9) ? 3'd2 : (r < 12) ? 3'd3 : (r < 14) ? 3'd4 : 3'(r - 9);
                load(0, 5'(a), mk($urandom_range(0, 3) == 0, sq, 5'($urandom), 24'($urandom)));
            end
            for (int a = 0; a < 16; a++) load(1, 5'(a), 33'($urandom));
            for (int c = 0; c < 100; c++) begin
                opcode    = 4'($urandom);
                eqb       = 1'($urandom);
                mem_ready = ($urandom_range(0, 2) != 0);
                start     = ($urandom_range(0, 5) == 0);
                load_en   = ($urandom_range(0, 9) == 0);
                load_sel  = 1'($urandom);
                load_addr = 5'($urandom);
                load_data = {1'($urandom), 32'($urandom)};
                cycle();
                n_total++; if (ctrl !== model_ctrl()) $display("FAIL rand%0d.%0d ctrl: got %h want %h", p, c, ctrl, model_ctrl()); else n_pass++;
                n_total++; if (upc !== 5'(m_upc)) $display("FAIL rand%0d.%0d upc: got %0d want %0d", p, c, upc, m_upc); else n_pass++;
                n_total++; if ({running, halted} !== {m_run, m_halt}) $display("FAIL rand%0d.%0d state: got %b%b want %b%b", p, c, running, halted, m_run, m_halt); else n_pass++;
                n_total++; if (seq_err !== m_err) $display("FAIL rand%0d.%0d seq_err: got %b want %b", p, c, seq_err, m_err); else n_pass++;
                n_total++; if (cycle_count !== 16'(m_cnt)) $display("FAIL rand%0d.%0d count: got %0d want %0d", p, c, cycle_count, m_cnt); else n_pass++;
            end
            start = 0; load_en = 0;
        end
    endtask

    initial begin
        rst_n = 0; start = 0; opcode = 0; eqb = 0; mem_ready = 1;
        load_en = 0; load_sel = 0; load_addr = 0; load_data = 0;
        model_reset();
        test_reset();
        fill_halt();
        test_linear();
        test_dispatch();
        test_branch();
        test_stall();
        test_errors_wrap();
        test_load_in_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised microprogrammed control sequencer for the 16-bit multicycle datapath.
- Replaces hand-driven per-cycle control stimulus: holds a loadable microcode store and an opcode dispatch table, and steps a micro-PC each clock.
- Emits a packed control word (pc_wr, alu_op, alu_srcB, reg_wr, memr, ...) to data_path.
- Supports sequential step, fetch return, opcode dispatch, eqb branch, memory wait-stall and halt.

Parameters:
CW_WIDTH, 24, width of control field driven to datapath
UADDR_WIDTH, 5, micro-address width; store depth = 2**UADDR_WIDTH
OPCODE_WIDTH, 4, opcode width; dispatch table depth = 2**OPCODE_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  IDLE/HALT -> RUN at micro-address 0
opcode  input  OPCODE_WIDTH  ir opcode field, sampled on DISPATCH
eqb  input  1  datapath equality flag, sampled on BRANCH_EQ
mem_ready  input  1  memory handshake; low stalls a WAIT microword
load_en  input  1  write microcode store or dispatch table
load_sel  input  1  0 = microcode store, 1 = dispatch table
load_addr  input  UADDR_WIDTH  store address; low OPCODE_WIDTH bits index table
load_data  input  CW_WIDTH+UADDR_WIDTH+4  microword {wait, seq[2:0], target, ctrl}; table uses low UADDR_WIDTH bits
ctrl  output  CW_WIDTH  control word to datapath
upc  output  UADDR_WIDTH  current micro-PC
running  output  1  high in RUN
halted  output  1  high in HALT
seq_err  output  1  sticky; set on reserved seq code
cycle_count  output  16  RUN cycles since last start, saturating

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; upc = 0; ctrl = 0; running = 0; halted = 0; seq_err = 0; cycle_count = 0.
  - Store and table contents are not reset.
- States:
  - IDLE: outputs zero. start -> RUN with upc = 0, cycle_count = 0, seq_err cleared.
  - RUN: ctrl = ctrl field of store[upc] (combinational from the upc register). cycle_count += 1 per RUN cycle, saturating at 16'hFFFF.
  - HALT: ctrl = 0, halted = 1, upc frozen. start -> RUN at upc = 0; counters clear as in IDLE.
- Next-upc rules in RUN, from seq of store[upc]:
  - 000 NEXT: upc+1, wraps modulo 2**UADDR_WIDTH.
  - 001 FETCH: 0.
  - 010 DISPATCH: table[opcode].
  - 011 BRANCH_EQ: target if eqb = 1, else upc+1.
  - 100 HALT: go to HALT. ctrl of the halting word is still driven for that one cycle.
  - 101-111: treated as HALT, and seq_err is set.
- Wait/stall:
  - If the wait bit = 1 and mem_ready = 0: upc holds and ctrl stays asserted.
  - No seq action is taken; cycle_count still increments.
  - Advance occurs on the first edge with mem_ready = 1.
- Loads:
  - Accepted only in IDLE or HALT; written at the rising edge. load_en in RUN is ignored.
  - Load and start in the same cycle: the load commits, and RUN starts using the new contents at the next edge.
- start in RUN: ignored.
- Reset mid-RUN: immediate return to IDLE, ctrl = 0 asynchronously.
- Latency:
  - The first ctrl word appears in the cycle after the start edge.
  - A DISPATCH target's ctrl appears one cycle after the DISPATCH word.

Test Plan:
- Reset then idle: rst_n low at t = 0, released -> ctrl = 0, upc = 0, running = 0, halted = 0, cycle_count = 0; load_en in RUN leaves contents unchanged.
- Linear program:
  - Load words 0..2 as NEXT with ctrl = 24'h000001, 24'h000002, 24'h000004, and word 3 as HALT with ctrl = 24'h000008.
  - Pulse start -> ctrl sequence 1, 2, 4, 8 on consecutive cycles, then halted = 1, ctrl = 0, cycle_count = 4.
- Dispatch:
  - Table[4'h3] = 5'd10, table[4'hC] = 5'd20; word 1 = DISPATCH.
  - opcode = 4'h3 -> upc goes 0, 1, 10.
  - Re-run with opcode = 4'hC -> upc goes 0, 1, 20.
- Branch:
  - Word 2 = BRANCH_EQ with target = 5'd7.
  - eqb = 1 -> upc goes 2 -> 7.
  - eqb = 0 -> upc goes 2 -> 3.
- Stall: word 1 has wait = 1; hold mem_ready = 0 for 3 cycles -> upc = 1 for 4 cycles, ctrl constant; cycle_count increments each cycle; advances to 2 after mem_ready = 1.
- Errors and wrap:
  - Word 0 seq = 3'b110 -> HALT with seq_err = 1; seq_err clears on next start.
  - Word 31 = NEXT, entered via branch -> upc wraps to 0.
  - rst_n low during RUN -> ctrl = 0 immediately.
